// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - per-channel 2-FF synchroniser and stability FSM with rise/fall pulses
module input_debouncer #(
   parameter int WIDTH         = 4,
   parameter int STABLE_CYCLES = 16
) (
   input  logic             clk_i,
   input  logic             nrst_i,
   input  logic [WIDTH-1:0] raw_i,
   output logic [WIDTH-1:0] level_o,
   output logic [WIDTH-1:0] rise_o,
   output logic [WIDTH-1:0] fall_o
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_ZERO = '0;
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_LOW     = 2'd0,
      S_TO_HIGH = 2'd1,
      S_HIGH    = 2'd2,
      S_TO_LOW  = 2'd3
   } state_t;

   logic [WIDTH-1:0] sync1_q, sync1_d;
   logic [WIDTH-1:0] sync2_q, sync2_d;
   logic [WIDTH-1:0] level_q, level_d;
   logic [WIDTH-1:0] rise_q, rise_d;
   logic [WIDTH-1:0] fall_q, fall_d;
   state_t           state_q [WIDTH];
   state_t           state_d [WIDTH];
   logic [CW-1:0]    cnt_q   [WIDTH];
   logic [CW-1:0]    cnt_d   [WIDTH];

   // Two-stage synchroniser; the FSMs only ever look at the second stage.
   always_comb begin
      sync1_d = raw_i;
      sync2_d = sync1_q;
   end

   // Per-channel stability FSM: a new level is accepted only after an unbroken run
   // of STABLE_CYCLES equal samples; any reversal drops back and restarts the count.
   always_comb begin
      level_d = level_q;
      rise_d  = '0;
      fall_d  = '0;
      for (int k = 0; k < WIDTH; k++) begin
         state_d[k] = state_q[k];
         cnt_d[k]   = cnt_q[k];
         case (state_q[k])
            S_LOW: begin
               if (sync2_q[k]) begin
                  state_d[k] = S_TO_HIGH;
                  cnt_d[k]   = CNT_ONE;
               end else begin
                  cnt_d[k]   = CNT_ZERO;
               end
            end
            S_TO_HIGH: begin
               if (!sync2_q[k]) begin
                  state_d[k] = S_LOW;
                  cnt_d[k]   = CNT_ZERO;
               end else if (cnt_q[k] == CNT_LAST) begin
                  state_d[k] = S_HIGH;
                  cnt_d[k]   = CNT_ZERO;
                  level_d[k] = 1'b1;
                  rise_d[k]  = 1'b1;
               end else begin
                  cnt_d[k]   = cnt_q[k] + CNT_ONE;
               end
            end
            S_HIGH: begin
               if (!sync2_q[k]) begin
                  state_d[k] = S_TO_LOW;
                  cnt_d[k]   = CNT_ONE;
               end else begin
                  cnt_d[k]   = CNT_ZERO;
               end
            end
            S_TO_LOW: begin
               if (sync2_q[k]) begin
                  state_d[k] = S_HIGH;
                  cnt_d[k]   = CNT_ZERO;
               end else if (cnt_q[k] == CNT_LAST) begin
                  state_d[k] = S_LOW;
                  cnt_d[k]   = CNT_ZERO;
                  level_d[k] = 1'b0;
                  fall_d[k]  = 1'b1;
               end else begin
                  cnt_d[k]   = cnt_q[k] + CNT_ONE;
               end
            end
            default: begin
               state_d[k] = S_LOW;
               cnt_d[k]   = CNT_ZERO;
               level_d[k] = 1'b0;
            end
         endcase
      end
   end

   // State registers; reset clears everything so no pulse appears on entry or exit.
   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         sync1_q <= '0;
         sync2_q <= '0;
         level_q <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
         for (int k = 0; k < WIDTH; k++) begin
            state_q[k] <= S_LOW;
            cnt_q[k]   <= CNT_ZERO;
         end
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         for (int k = 0; k < WIDTH; k++) begin
            state_q[k] <= state_d[k];
            cnt_q[k]   <= cnt_d[k];
         end
      end
   end

   assign level_o = level_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

endmodule

// File: tb/tb_input_debouncer.sv
// tb/tb_input_debouncer.sv - scoreboard bench for input_debouncer against a sample-window model
module tb_input_debouncer;

   localparam int W = 4;
   localparam int N = 4;

   logic         clk = 1'b0;
   logic         nrst_i;
   logic [W-1:0] raw_i;
   logic [W-1:0] level_o, rise_o, fall_o;

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic [W-1:0] lvl;
      logic [W-1:0] rise;
      logic [W-1:0] fall;
   } exp_t;

   exp_t sb[$];

   // Reference model state: raw samples pass through two delay stages, then each
   // channel keeps a window of the last N samples seen since its previous accept.
   logic [W-1:0] m_s1, m_s2, m_lvl;
   logic [N-1:0] win [W];
   int           fill [W];

   input_debouncer #(.WIDTH(W), .STABLE_CYCLES(N)) dut (
      .clk_i  (clk),
      .nrst_i (nrst_i),
      .raw_i  (raw_i),
      .level_o(level_o),
      .rise_o (rise_o),
      .fall_o (fall_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
      end
   endtask

   // Model: one step per rising edge; pushes the outputs expected after that edge.
   always @(posedge clk) begin
      exp_t e;
      e.rise = '0;
      e.fall = '0;
      if (!nrst_i) begin
         m_s1  = '0;
         m_s2  = '0;
         m_lvl = '0;
         for (int k = 0; k < W; k++) begin
            win[k]  = '0;
            fill[k] = 0;
         end
      end else begin
         for (int k = 0; k < W; k++) begin
            win[k] = {win[k][N-2:0], m_s2[k]};
            fill[k]++;
            if (fill[k] >= N && win[k] == {N{~m_lvl[k]}}) begin
               m_lvl[k] = ~m_lvl[k];
               if (m_lvl[k]) e.rise[k] = 1'b1;
               else          e.fall[k] = 1'b1;
               fill[k] = 0;
            end
         end
         m_s2 = m_s1;
         m_s1 = raw_i;
      end
      e.lvl = m_lvl;
      sb.push_back(e);
   end

   // Monitor: every falling edge the DUT presents a result for the preceding edge.
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("level", level_o, e.lvl);
         check("rise", rise_o, e.rise);
         check("fall", fall_o, e.fall);
         check("rise_and_fall", rise_o & fall_o, '0);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   // Asynchronous reset entry: outputs must clear before the next clock edge.
   task automatic async_reset(input int hold);
      #2;
      nrst_i = 1'b0;
      #1;
      check("async_rst_level", level_o, '0);
      check("async_rst_rise", rise_o, '0);
      check("async_rst_fall", fall_o, '0);
      cyc(hold);
      nrst_i = 1'b1;
   endtask

   initial begin
      nrst_i = 1'b0;
      raw_i  = 4'hF;
      // Reset held with all inputs high, then released: all four rise together.
      cyc(5);
      nrst_i = 1'b1;
      cyc(10);
      raw_i = 4'h0;
      cyc(10);
      // Clean press on channel 0.
      raw_i[0] = 1'b1;
      cyc(10);
      raw_i[0] = 1'b0;
      cyc(10);
      // Bounce on channel 0, then settle high.
      for (int i = 0; i < 4; i++) begin
         raw_i[0] = (i % 2 == 0);
         cyc(2);
      end
      raw_i[0] = 1'b1;
      cyc(10);
      // Three-cycle glitch on channel 1.
      raw_i[1] = 1'b1;
      cyc(3);
      raw_i[1] = 1'b0;
      cyc(10);
      // Release channel 0.
      raw_i[0] = 1'b0;
      cyc(10);
      // Reset in the middle of a press on channel 2 while channel 3 is high.
      raw_i = 4'b1000;
      cyc(10);
      raw_i[2] = 1'b1;
      cyc(4);
      async_reset(3);
      cyc(12);
      // Random activity with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 20) raw_i[$urandom_range(0, W-1)] ^= 1'b1;
         else if (r < 22) raw_i = W'($urandom);
         else if (r == 50 && $urandom_range(0, 9) == 0) async_reset($urandom_range(2, 4));
         if ($urandom_range(0, 9) == 0) cyc($urandom_range(4, 12));
         else cyc(1);
      end
      cyc(3);
      check("scoreboard_drained", W'(sb.size() > 1), '0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
